// File: rtl/comparator_bist.sv
// ---------------------------------------------------------------------------
// comparator_bist
//
// Self-test sequencer for the 1-bit magnitude comparator (comparator1bit).
// It drives the comparator operands through the four combinations
// {A,B} = 00, 01, 10, 11. Each combination is held for SETTLE_CYCLES cycles.
// The three result bits are then checked in a single CHECK cycle, and any
// mismatch is recorded in fail_vec_o.
//
// Parameters
//   SETTLE_CYCLES  cycles each pattern is held before sampling (1..15,
//                  a value of 0 is treated as 1)
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        single-cycle request to run the self-test
//   a_o, b_o       registered comparator operands
//   o1_i           comparator result, expected A <  B
//   o2_i           comparator result, expected A == B
//   o3_i           comparator result, expected A >  B
//   busy_o         high while a run is in progress (DRIVE/CHECK)
//   done_o         high from end of run until next accepted start or reset
//   pass_o         done_o and no pattern failed
//   fail_vec_o     bit i set if pattern i mismatched
//
// Configuration
//   BIST_STOP_ON_FAIL_EN  when defined, the first failing CHECK ends the run
//                         immediately, leaving the failing pattern on a_o/b_o
// ---------------------------------------------------------------------------
module comparator_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       a_o,
    output logic       b_o,
    input  logic       o1_i,
    input  logic       o2_i,
    input  logic       o3_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_vec_o
);

    // Zero settle time is promoted to one cycle; the counter counts down
    // from SETTLE-1 to 0, so DRIVE lasts exactly SETTLE cycles.
    localparam int         SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [3:0] RELOAD     = 4'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] fail_q, fail_d;
    logic [2:0] expected;
    logic       mismatch;

    // State, pattern index, settle counter and failure record.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            fail_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    // Expected {o1,o2,o3} for the pattern currently on the operands.
    // Any deviation counts, including non-one-hot results.
    always_comb begin
        expected = 3'b010;
        unique case (idx_q)
            2'd0:    expected = 3'b010;
            2'd1:    expected = 3'b100;
            2'd2:    expected = 3'b001;
            default: expected = 3'b010;
        endcase
        mismatch = ({o1_i, o2_i, o3_i} != expected);
    end

    // Next-state logic. start is only looked at in IDLE and DONE, so it is
    // naturally ignored while busy and on the cycle DONE is entered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = DRIVE;
                    idx_d   = 2'd0;
                    cnt_d   = RELOAD;
                    fail_d  = 4'd0;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_d[idx_q] = 1'b1;
                end
`ifdef BIST_STOP_ON_FAIL_EN
                if (idx_q == 2'd3 || mismatch) begin
`else
                if (idx_q == 2'd3) begin
`endif
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = RELOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The pattern index register doubles as the registered operand pair.
    assign a_o        = idx_q[1];
    assign b_o        = idx_q[0];
    assign busy_o     = (state_q == DRIVE) || (state_q == CHECK);
    assign done_o     = (state_q == DONE);
    assign pass_o     = done_o && (fail_q == 4'd0);
    assign fail_vec_o = fail_q;

endmodule

// File: tb/tb_comparator_bist.sv
// ---------------------------------------------------------------------------
// tb_comparator_bist
//
// Bench for comparator_bist. Two instances are used: dutX with the default
// settle time (2) and dutY with SETTLE_CYCLES = 0. A behavioural comparator
// with selectable faults answers both. A cycle-offset model predicts every
// output on every cycle. Hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_comparator_bist;

    localparam int SX = 2;
    localparam int SY = 0;
`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] fv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstX, startX, aX, bX, o1X, o2X, o3X, busyX, doneX, passX;
    logic       rstY, startY, aY, bY, o1Y, o2Y, o3Y, busyY, doneY, passY;
    logic [3:0] fvX, fvY;
    int         mode;

    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    bit         checkEn = 1'b0;

    // model state, advanced on each rising edge
    bit         startedX = 1'b0, startedY = 1'b0;
    int         tX = 0, tY = 0;
    logic [3:0] faultsX = 4'd0, faultsY = 4'd0;

    always #5 clk = ~clk;

    comparator_bist #(.SETTLE_CYCLES(SX)) dutX (
        .clk_i(clk), .rst_i(rstX), .start_i(startX),
        .a_o(aX), .b_o(bX), .o1_i(o1X), .o2_i(o2X), .o3_i(o3X),
        .busy_o(busyX), .done_o(doneX), .pass_o(passX), .fail_vec_o(fvX)
    );

    comparator_bist #(.SETTLE_CYCLES(SY)) dutY (
        .clk_i(clk), .rst_i(rstY), .start_i(startY),
        .a_o(aY), .b_o(bY), .o1_i(o1Y), .o2_i(o2Y), .o3_i(o3Y),
        .busy_o(busyY), .done_o(doneY), .pass_o(passY), .fail_vec_o(fvY)
    );

    // Behavioural comparator: mode 0 correct, 1 o2 stuck at 0, 2 o1 stuck at 1.
    function automatic logic [2:0] respond(input int m, input logic a, input logic b);
        logic [2:0] r;
        r = {(!a && b), (a == b), (a && !b)};
        if (m == 1) r[1] = 1'b0;
        if (m == 2) r[2] = 1'b1;
        return r;
    endfunction

    always_comb {o1X, o2X, o3X} = respond(mode, aX, bX);
    always_comb {o1Y, o2Y, o3Y} = respond(mode, aY, bY);

    // Which patterns a comparator in mode m gets wrong, from the relations.
    function automatic logic [3:0] faultsOf(input int m);
        logic [3:0] f;
        int         av, bv;
        logic [2:0] want;
        f = 4'd0;
        for (int i = 0; i < 4; i++) begin
            av   = i / 2;
            bv   = i % 2;
            want = {av < bv, av == bv, av > bv};
            f[i] = (respond(m, av[0], bv[0]) != want);
        end
        return f;
    endfunction

    function automatic int lastPattern(input logic [3:0] f);
        if (STOP) begin
            for (int j = 0; j < 4; j++) if (f[j]) return j;
        end
        return 3;
    endfunction

    // Expected outputs t cycles after the accepting edge.
    function automatic exp_t modelOut(input int s, input bit started, input int t,
                                      input logic [3:0] f);
        exp_t       e;
        int         p, last, pat;
        logic [1:0] ab;
        e = '0;
        if (!started) return e;
        p    = ((s < 1) ? 1 : s) + 1;
        last = lastPattern(f);
        if (t <= (last + 1) * p) begin
            e.busy = 1'b1;
            pat    = (t - 1) / p;
            for (int j = 0; j < 4; j++) if ((j + 1) * p < t) e.fv[j] = f[j];
        end else begin
            e.done = 1'b1;
            pat    = last;
            for (int j = 0; j <= last; j++) e.fv[j] = f[j];
            e.pass = (e.fv == 4'd0);
        end
        ab  = 2'(pat);
        e.a = ab[1];
        e.b = ab[0];
        return e;
    endfunction

    always @(posedge clk) begin
        if (rstX) begin
            startedX <= 1'b0;
            tX       <= 0;
        end else if (startX && !modelOut(SX, startedX, tX, faultsX).busy) begin
            startedX <= 1'b1;
            tX       <= 1;
            faultsX  <= faultsOf(mode);
        end else if (startedX && tX < 10000) begin
            tX <= tX + 1;
        end
        if (rstY) begin
            startedY <= 1'b0;
            tY       <= 0;
        end else if (startY && !modelOut(SY, startedY, tY, faultsY).busy) begin
            startedY <= 1'b1;
            tY       <= 1;
            faultsY  <= faultsOf(mode);
        end else if (startedY && tY < 10000) begin
            tY <= tY + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, want);
        end
    endtask

    // Advance to the next falling edge and compare both DUTs with the model.
    task automatic applyStimulus();
        exp_t ex, ey;
        @(negedge clk);
        cycle++;
        if (checkEn) begin
            ex = modelOut(SX, startedX, tX, faultsX);
            ey = modelOut(SY, startedY, tY, faultsY);
            checkOutput("modelX", {aX, bX, busyX, doneX, passX, fvX}, ex);
            checkOutput("modelY", {aY, bY, busyY, doneY, passY, fvY}, ey);
        end
    endtask

    task automatic waitDone(input bit useY, input int from, output int cyc);
        cyc = from;
        while (!(useY ? doneY : doneX) && cyc < 60) begin
            applyStimulus();
            cyc++;
        end
        checkOutput("doneTimeout", {31'd0, (useY ? doneY : doneX)}, 32'd1);
    endtask

    task automatic pulseX();
        startX = 1'b1;
        applyStimulus();
        startX = 1'b0;
    endtask

    initial begin
        logic [1:0] abExp [12];
        int         cyc;
        abExp = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01,
                  2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
        rstX = 1'b1; rstY = 1'b1; startX = 1'b0; startY = 1'b0; mode = 0;
        applyStimulus();
        checkEn = 1'b1;
        applyStimulus();
        checkOutput("resetX", {aX, bX, busyX, doneX, passX, fvX}, 32'd0);
        checkOutput("resetY", {aY, bY, busyY, doneY, passY, fvY}, 32'd0);
        rstX = 1'b0; rstY = 1'b0;
        applyStimulus();
        applyStimulus();

        // good comparator: operand sequence and completion time
        pulseX();
        for (int i = 0; i < 12; i++) begin
            checkOutput("abSeq", {30'd0, aX, bX}, {30'd0, abExp[i]});
            applyStimulus();
        end
        checkOutput("goodEnd", {busyX, doneX, passX, fvX}, {3'b011, 4'b0000});

        // second start mid-run is ignored
        pulseX();
        applyStimulus();
        applyStimulus();
        startX = 1'b1;
        applyStimulus();
        startX = 1'b0;
        waitDone(1'b0, 4, cyc);
        checkOutput("midStartDone", cyc, 13);

        // start in DONE restarts and clears results
        pulseX();
        checkOutput("restartClear", {busyX, doneX, passX, fvX}, {3'b100, 4'b0000});
        waitDone(1'b0, 1, cyc);
        checkOutput("restartDone", cyc, 13);
        checkOutput("restartPass", {31'd0, passX}, 32'd1);

        // o2 stuck at 0
        mode = 1;
        pulseX();
        waitDone(1'b0, 1, cyc);
        checkOutput("o2StuckCycles", cyc, STOP ? 4 : 13);
        checkOutput("o2StuckFv", {28'd0, fvX}, STOP ? 32'h1 : 32'h9);
        checkOutput("o2StuckFlags", {busyX, doneX, passX}, 3'b010);

        // o1 stuck at 1
        mode = 2;
        pulseX();
        waitDone(1'b0, 1, cyc);
        checkOutput("o1StuckCycles", cyc, STOP ? 4 : 13);
        checkOutput("o1StuckFv", {28'd0, fvX}, STOP ? 32'h1 : 32'hD);
        checkOutput("o1StuckAB", {aX, bX}, STOP ? 2'b00 : 2'b11);
        mode = 0;
        applyStimulus();

        // zero settle time behaves as one
        startY = 1'b1;
        applyStimulus();
        startY = 1'b0;
        checkOutput("settle0First", {aY, bY, busyY}, 3'b001);
        waitDone(1'b1, 1, cyc);
        checkOutput("settle0Done", cyc, 9);
        checkOutput("settle0Pass", {31'd0, passY}, 32'd1);

        // reset during DRIVE of pattern 2, with start also high
        pulseX();
        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput("preResetAB", {aX, bX, busyX}, 3'b101);
        rstX = 1'b1;
        startX = 1'b1;
        applyStimulus();
        checkOutput("midReset", {aX, bX, busyX, doneX, passX, fvX}, 32'd0);
        rstX = 1'b0;
        startX = 1'b0;
        applyStimulus();
        checkOutput("idleAfterReset", {aX, bX, busyX, doneX, passX, fvX}, 32'd0);
        pulseX();
        waitDone(1'b0, 1, cyc);
        checkOutput("afterResetDone", cyc, 13);
        checkOutput("afterResetEnd", {aX, bX, passX, fvX}, {3'b111, 4'b0000});

        applyStimulus();
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
